// File: rtl/marker_overlay_pkg.sv
// marker_overlay_pkg: marker mode codes, RGB pixel type and the 50% blend
// helper shared by the marker_overlay top and its per-marker hit units.
package marker_overlay_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_CROSS  = 2'd1;
  localparam logic [1:0] MODE_CIRCLE = 2'd2;
  localparam logic [1:0] MODE_SQUARE = 2'd3;

  typedef logic [23:0] rgb_t;

  // Per-channel (a + b) >> 1; the 9-bit sums keep the carry before halving.
  function automatic rgb_t blend50(input rgb_t a, input rgb_t b);
    logic [8:0] s_r;
    logic [8:0] s_g;
    logic [8:0] s_b;
    s_r = {1'b0, a[23:16]} + {1'b0, b[23:16]};
    s_g = {1'b0, a[15:8]}  + {1'b0, b[15:8]};
    s_b = {1'b0, a[7:0]}   + {1'b0, b[7:0]};
    return {s_r[8:1], s_g[8:1], s_b[8:1]};
  endfunction

endpackage

// File: rtl/marker_overlay_hit.sv
// marker_hit: geometry for one marker. Stage 1 registers the signed offsets
// of the current pixel from the marker centre (magnitudes, squared distance,
// zero flags); stage 2 registers whether the pixel lies on the marker shape.
module marker_hit
  import marker_overlay_pkg::*;
#(
  parameter int XW     = 11,
  parameter int YW     = 10,
  parameter int RADIUS = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] x_pos,
  input  logic [YW-1:0] y_pos,
  input  logic [XW-1:0] mx,
  input  logic [YW-1:0] my,
  input  logic          en,
  input  logic [1:0]    mode,
  output logic          hit
);

  localparam int MW = (XW > YW) ? XW : YW;
  localparam int AW = MW + 1;
  localparam int DW = 2 * MW + 3;

  // Circle ring is R*R - R .. R*R + R, which gives a closed one-pixel outline.
  localparam logic [DW-1:0] D2_LO = DW'(RADIUS * RADIUS - RADIUS);
  localparam logic [DW-1:0] D2_HI = DW'(RADIUS * RADIUS + RADIUS);
  localparam logic [AW-1:0] RAD_A = AW'(RADIUS);

  logic signed [XW:0] dx;
  logic signed [YW:0] dy;
  logic [XW:0]        adx_p1_d, adx_p1_q;
  logic [YW:0]        ady_p1_d, ady_p1_q;
  logic [DW-1:0]      d2_p1_d, d2_p1_q;
  logic               eqx_p1_d, eqx_p1_q;
  logic               eqy_p1_d, eqy_p1_q;
  logic [1:0]         mode_p1_d, mode_p1_q;
  logic [AW-1:0]      amax;
  logic               hit_p2_d, hit_p2_q;

  // Stage 1 math: one extra bit keeps left/above offsets negative, so markers
  // near the frame edge clip instead of wrapping round to the far side.
  always_comb begin
    dx        = $signed({1'b0, x_pos}) - $signed({1'b0, mx});
    dy        = $signed({1'b0, y_pos}) - $signed({1'b0, my});
    adx_p1_d  = dx[XW] ? $unsigned(-dx) : $unsigned(dx);
    ady_p1_d  = dy[YW] ? $unsigned(-dy) : $unsigned(dy);
    d2_p1_d   = DW'(adx_p1_d) * DW'(adx_p1_d) + DW'(ady_p1_d) * DW'(ady_p1_d);
    eqx_p1_d  = (dx == '0);
    eqy_p1_d  = (dy == '0);
    mode_p1_d = en ? mode : MODE_OFF;
  end

  // ---- stage 1 boundary: offset datapath (no reset needed) ----
  always_ff @(posedge clk) begin
    adx_p1_q <= adx_p1_d;
    ady_p1_q <= ady_p1_d;
    d2_p1_q  <= d2_p1_d;
    eqx_p1_q <= eqx_p1_d;
    eqy_p1_q <= eqy_p1_d;
  end

  // Stage 1 control: effective mode, with disabled markers folded to off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_p1_q <= MODE_OFF;
    else        mode_p1_q <= mode_p1_d;
  end

  // Stage 2 shape test on the registered offsets.
  always_comb begin
    amax     = (AW'(adx_p1_q) > AW'(ady_p1_q)) ? AW'(adx_p1_q) : AW'(ady_p1_q);
    hit_p2_d = 1'b0;
    case (mode_p1_q)
      MODE_CROSS:  hit_p2_d = eqx_p1_q | eqy_p1_q;
      MODE_CIRCLE: hit_p2_d = (d2_p1_q >= D2_LO) && (d2_p1_q <= D2_HI);
      MODE_SQUARE: hit_p2_d = (amax == RAD_A);
      default:     hit_p2_d = 1'b0;
    endcase
  end

  // ---- stage 2 boundary: registered hit ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_p2_q <= 1'b0;
    else        hit_p2_q <= hit_p2_d;
  end

  assign hit = hit_p2_q;

endmodule

// File: rtl/marker_overlay.sv
// marker_overlay: draws up to NUM_MARKERS crosshair/circle/square markers on
// a pixel stream with a fixed two-cycle latency. Marker settings are captured
// into shadows on each vsync rising edge so a frame never tears.
// Build option: define MARKER_OVERLAY_BLEND_EN to mix marker colour with the
// underlying pixel at 50% instead of replacing it.
module marker_overlay
  import marker_overlay_pkg::*;
#(
  parameter int NUM_MARKERS = 2,
  parameter int XW          = 11,
  parameter int YW          = 10,
  parameter int RADIUS      = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      de_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [23:0]               pixel_in,
  input  logic [NUM_MARKERS*XW-1:0] marker_x,
  input  logic [NUM_MARKERS*YW-1:0] marker_y,
  input  logic [NUM_MARKERS-1:0]    marker_en,
  input  logic [NUM_MARKERS*2-1:0]  marker_mode,
  input  logic [NUM_MARKERS*24-1:0] marker_colour,
  output logic                      de_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [23:0]               pixel_out,
  output logic                      frame_latched
);

  logic                      vs_rise;
  logic                      de_fall;
  logic [XW-1:0]             x_pos_d, x_pos_q;
  logic [YW-1:0]             y_pos_d, y_pos_q;
  logic                      frame_latched_d, frame_latched_q;

  logic [NUM_MARKERS*XW-1:0] sh_x_d, sh_x_q;
  logic [NUM_MARKERS*YW-1:0] sh_y_d, sh_y_q;
  logic [NUM_MARKERS-1:0]    sh_en_d, sh_en_q;
  logic [NUM_MARKERS*2-1:0]  sh_mode_d, sh_mode_q;
  logic [NUM_MARKERS*24-1:0] sh_col_d, sh_col_q;

  logic                      de_p1_d, de_p1_q;
  logic                      hs_p1_d, hs_p1_q;
  logic                      vs_p1_d, vs_p1_q;
  rgb_t                      pix_p1_d, pix_p1_q;
  logic                      de_p2_d, de_p2_q;
  logic                      hs_p2_d, hs_p2_q;
  logic                      vs_p2_d, vs_p2_q;
  rgb_t                      pix_p2_d, pix_p2_q;

  logic [NUM_MARKERS-1:0]    hit;
  logic                      hit_any;
  rgb_t                      hit_col;
  rgb_t                      pix_mux;

  // Position counters and shadow capture. The stage-1 de/vsync registers are
  // the previous-cycle values, so they double as the edge detectors.
  always_comb begin
    vs_rise         = vsync_in & ~vs_p1_q;
    de_fall         = ~de_in & de_p1_q;
    x_pos_d         = x_pos_q;
    y_pos_d         = y_pos_q;
    sh_x_d          = sh_x_q;
    sh_y_d          = sh_y_q;
    sh_en_d         = sh_en_q;
    sh_mode_d       = sh_mode_q;
    sh_col_d        = sh_col_q;
    frame_latched_d = vs_rise;
    if (vs_rise) begin
      x_pos_d = '0;
      y_pos_d = '0;
    end else if (de_fall) begin
      x_pos_d = '0;
      y_pos_d = y_pos_q + YW'(1);
    end else if (de_in) begin
      x_pos_d = x_pos_q + XW'(1);
    end
    if (vs_rise) begin
      sh_x_d    = marker_x;
      sh_y_d    = marker_y;
      sh_en_d   = marker_en;
      sh_mode_d = marker_mode;
      sh_col_d  = marker_colour;
    end
  end

  // Counter, shadow and frame pulse state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos_q         <= '0;
      y_pos_q         <= '0;
      sh_x_q          <= '0;
      sh_y_q          <= '0;
      sh_en_q         <= '0;
      sh_mode_q       <= '0;
      sh_col_q        <= '0;
      frame_latched_q <= 1'b0;
    end else begin
      x_pos_q         <= x_pos_d;
      y_pos_q         <= y_pos_d;
      sh_x_q          <= sh_x_d;
      sh_y_q          <= sh_y_d;
      sh_en_q         <= sh_en_d;
      sh_mode_q       <= sh_mode_d;
      sh_col_q        <= sh_col_d;
      frame_latched_q <= frame_latched_d;
    end
  end

  // Sync and pixel pipe next-state for both stages.
  always_comb begin
    de_p1_d  = de_in;
    hs_p1_d  = hsync_in;
    vs_p1_d  = vsync_in;
    pix_p1_d = pixel_in;
    de_p2_d  = de_p1_q;
    hs_p2_d  = hs_p1_q;
    vs_p2_d  = vs_p1_q;
    pix_p2_d = pix_p1_q;
  end

  // ---- stage 1 boundary: sync controls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p1_q <= 1'b0;
      hs_p1_q <= 1'b0;
      vs_p1_q <= 1'b0;
    end else begin
      de_p1_q <= de_p1_d;
      hs_p1_q <= hs_p1_d;
      vs_p1_q <= vs_p1_d;
    end
  end

  // Stage 1 pixel data; it is flushed by the stream itself, so no reset.
  always_ff @(posedge clk) begin
    pix_p1_q <= pix_p1_d;
  end

  // ---- stage 2 boundary: registers that drive the outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p2_q  <= 1'b0;
      hs_p2_q  <= 1'b0;
      vs_p2_q  <= 1'b0;
      pix_p2_q <= '0;
    end else begin
      de_p2_q  <= de_p2_d;
      hs_p2_q  <= hs_p2_d;
      vs_p2_q  <= vs_p2_d;
      pix_p2_q <= pix_p2_d;
    end
  end

  for (genvar i = 0; i < NUM_MARKERS; i++) begin : g_marker
    marker_hit #(
      .XW     (XW),
      .YW     (YW),
      .RADIUS (RADIUS)
    ) u_hit (
      .clk   (clk),
      .rst_n (rst_n),
      .x_pos (x_pos_q),
      .y_pos (y_pos_q),
      .mx    (sh_x_q[i*XW +: XW]),
      .my    (sh_y_q[i*YW +: YW]),
      .en    (sh_en_q[i]),
      .mode  (sh_mode_q[i*2 +: 2]),
      .hit   (hit[i])
    );
  end

  // Priority mux: scanning down to index 0 lets the lowest-index hit win;
  // blanking pixels are always passed through untouched.
  always_comb begin
    hit_any = 1'b0;
    hit_col = '0;
    for (int i = NUM_MARKERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_col = sh_col_q[i*24 +: 24];
      end
    end
    pix_mux = pix_p2_q;
    if (de_p2_q && hit_any) begin
`ifdef MARKER_OVERLAY_BLEND_EN
      pix_mux = blend50(hit_col, pix_p2_q);
`else
      pix_mux = hit_col;
`endif
    end
  end

  assign de_out        = de_p2_q;
  assign hsync_out     = hs_p2_q;
  assign vsync_out     = vs_p2_q;
  assign pixel_out     = pix_mux;
  assign frame_latched = frame_latched_q;

endmodule

// File: tb/tb_marker_overlay.sv
// tb_marker_overlay: frame-level stimulus for marker_overlay with a scoreboard.
// The driver knows which (column,row) each active pixel is, predicts the
// output from the marker geometry and pushes it; a monitor pops and compares.
module tb_marker_overlay;

  localparam int NM = 2;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int R  = 6;
  localparam int W  = 64;
  localparam int H  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             de_in = 1'b0;
  logic             hsync_in = 1'b0;
  logic             vsync_in = 1'b0;
  logic [23:0]      pixel_in = '0;
  logic [NM*XW-1:0] marker_x = '0;
  logic [NM*YW-1:0] marker_y = '0;
  logic [NM-1:0]    marker_en = '0;
  logic [NM*2-1:0]  marker_mode = '0;
  logic [NM*24-1:0] marker_colour = '0;
  logic             de_out;
  logic             hsync_out;
  logic             vsync_out;
  logic [23:0]      pixel_out;
  logic             frame_latched;

  always #5 clk = ~clk;

  marker_overlay #(
    .NUM_MARKERS (NM),
    .XW          (XW),
    .YW          (YW),
    .RADIUS      (R)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .de_in         (de_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .pixel_in      (pixel_in),
    .marker_x      (marker_x),
    .marker_y      (marker_y),
    .marker_en     (marker_en),
    .marker_mode   (marker_mode),
    .marker_colour (marker_colour),
    .de_out        (de_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .pixel_out     (pixel_out),
    .frame_latched (frame_latched)
  );

  typedef struct {
    int          due;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
    int          r;
    int          c;
  } exp_t;

  typedef struct {
    int   due;
    logic v;
  } fl_t;

  exp_t q_exp[$];
  fl_t  q_fl[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Live marker settings (what the bench drives) and the frame's shadow copy.
  int          m_x[NM], m_y[NM], m_mode[NM];
  logic        m_en[NM];
  logic [23:0] m_col[NM];
  int          s_x[NM], s_y[NM], s_mode[NM];
  logic        s_en[NM];
  logic [23:0] s_col[NM];
  logic        prev_vs = 1'b0;
  logic        use_fix = 1'b0;
  logic [23:0] fix_pix = '0;

  function automatic bit on_shape(int mode, int dc, int dr);
    int d2, ac, ar;
    d2 = dc * dc + dr * dr;
    ac = (dc < 0) ? -dc : dc;
    ar = (dr < 0) ? -dr : dr;
    case (mode)
      1:       return (dc == 0) || (dr == 0);
      2:       return (d2 >= R * R - R) && (d2 <= R * R + R);
      3:       return ((ac > ar) ? ac : ar) == R;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(logic de, int r, int c, logic [23:0] pin);
    if (!de) return pin;
    for (int i = 0; i < NM; i++) begin
      if (s_en[i] && on_shape(s_mode[i], c - s_x[i], r - s_y[i])) begin
`ifdef MARKER_OVERLAY_BLEND_EN
        return {8'((int'(s_col[i][23:16]) + int'(pin[23:16])) / 2),
                8'((int'(s_col[i][15:8])  + int'(pin[15:8]))  / 2),
                8'((int'(s_col[i][7:0])   + int'(pin[7:0]))   / 2)};
`else
        return s_col[i];
`endif
      end
    end
    return pin;
  endfunction

  // Cycle counter: number of rising clock edges so far.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare every prediction that falls due on this edge.
  initial forever begin
    exp_t e;
    fl_t  f;
    @(posedge clk);
    #1;
    while (q_exp.size() > 0 && q_exp[0].due == cyc) begin
      e = q_exp.pop_front();
      checks++;
      if (de_out !== e.de || hsync_out !== e.hs || vsync_out !== e.vs || pixel_out !== e.pix) begin
        errors++;
        $display("FAIL stream r=%0d c=%0d: de/hs/vs=%b%b%b pixel=%h, expected de/hs/vs=%b%b%b pixel=%h",
                 e.r, e.c, de_out, hsync_out, vsync_out, pixel_out, e.de, e.hs, e.vs, e.pix);
      end
    end
    while (q_fl.size() > 0 && q_fl[0].due == cyc) begin
      f = q_fl.pop_front();
      checks++;
      if (frame_latched !== f.v) begin
        errors++;
        $display("FAIL frame_latched at cycle %0d: got %b, expected %b", cyc, frame_latched, f.v);
      end
    end
  end

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One pixel clock of stimulus plus its predicted response.
  task automatic drive(input logic de, input logic vs, input int r, input int c);
    logic rise;
    @(negedge clk);
    de_in    = de;
    vsync_in = vs;
    hsync_in = 1'($urandom_range(0, 1));
    pixel_in = use_fix ? fix_pix : 24'($urandom);
    for (int i = 0; i < NM; i++) begin
      marker_x[i*XW +: XW]      = XW'(m_x[i]);
      marker_y[i*YW +: YW]      = YW'(m_y[i]);
      marker_en[i]              = m_en[i];
      marker_mode[i*2 +: 2]     = 2'(m_mode[i]);
      marker_colour[i*24 +: 24] = m_col[i];
    end
    rise = vs && !prev_vs;
    if (rise) begin
      for (int i = 0; i < NM; i++) begin
        s_x[i]    = m_x[i];
        s_y[i]    = m_y[i];
        s_en[i]   = m_en[i];
        s_mode[i] = m_mode[i];
        s_col[i]  = m_col[i];
      end
    end
    prev_vs = vs;
    q_fl.push_back('{due: cyc + 1, v: rise});
    q_exp.push_back('{due: cyc + 2, de: de, hs: hsync_in, vs: vs,
                      pix: model_pix(de, r, c, pixel_in), r: r, c: c});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    de_in    = 1'b0;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    #1;
    chk("reset de_out", 24'(de_out), 24'h0);
    chk("reset hsync_out", 24'(hsync_out), 24'h0);
    chk("reset vsync_out", 24'(vsync_out), 24'h0);
    chk("reset pixel_out", pixel_out, 24'h0);
    chk("reset frame_latched", 24'(frame_latched), 24'h0);
    q_exp.delete();
    q_fl.delete();
    for (int i = 0; i < NM; i++) s_en[i] = 1'b0;
    prev_vs = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full frame: vsync pulse, blanking, H lines of W pixels + 1 blank each.
  // chg_at moves marker chg_idx mid-frame; rst_at resets mid-line and aborts.
  task automatic frame(input int chg_at, input int chg_idx, input int chg_x, input int rst_at);
    int k;
    k = 0;
    drive(1'b0, 1'b1, -1, -1);
    drive(1'b0, 1'b1, -1, -1);
    drive(1'b0, 1'b0, -1, -1);
    drive(1'b0, 1'b0, -1, -1);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (k == chg_at) m_x[chg_idx] = chg_x;
        if (k == rst_at) begin
          do_reset();
          return;
        end
        drive(1'b1, 1'b0, r, c);
        k++;
      end
      drive(1'b0, 1'b0, r, W);
    end
  endtask

  task automatic set_marker(input int i, input int mode, input int x, input int y,
                            input logic [23:0] col, input logic en);
    m_mode[i] = mode;
    m_x[i]    = x;
    m_y[i]    = y;
    m_col[i]  = col;
    m_en[i]   = en;
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    for (int i = 0; i < NM; i++) begin
      set_marker(i, 0, 0, 0, 24'h0, 1'b0);
      s_en[i] = 1'b0;
      s_x[i] = 0; s_y[i] = 0; s_mode[i] = 0; s_col[i] = '0;
    end
    do_reset();

    // Crosshair at (10,5) in red.
    set_marker(0, 1, 10, 5, 24'hFF0000, 1'b1);
    frame(-1, 0, 0, -1);

    // Circle centred at (30,15).
    set_marker(0, 2, 30, 15, 24'h12AB34, 1'b1);
    frame(-1, 0, 0, -1);

    // Priority: cross (green) through (20,10), square (blue) edge on (20,10).
    set_marker(0, 1, 20, 10, 24'h00FF00, 1'b1);
    set_marker(1, 3, 26, 10, 24'h0000FF, 1'b1);
    frame(-1, 0, 0, -1);
    m_en[0] = 1'b0;
    frame(-1, 0, 0, -1);

    // Shadow latch: move the crosshair x mid-frame from 10 to 40.
    set_marker(0, 1, 10, 5, 24'hFF0000, 1'b1);
    set_marker(1, 0, 0, 0, 24'h0, 1'b0);
    frame(10 * W + 3, 0, 40, -1);
    frame(-1, 0, 0, -1);

    // Corner marker at (0,0) over a fixed 0000FE background.
    set_marker(0, 1, 0, 0, 24'hFF0000, 1'b1);
    set_marker(1, 2, 0, 0, 24'h00FF00, 1'b1);
    use_fix = 1'b1;
    fix_pix = 24'h0000FE;
    frame(-1, 0, 0, -1);
    use_fix = 1'b0;

    // Random markers, including far coordinates, with random mid-frame moves.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NM; i++) begin
        set_marker(i, int'($urandom_range(0, 3)),
                   $urandom_range(0, 1) ? int'($urandom_range(0, 80)) : int'($urandom_range(2030, 2047)),
                   $urandom_range(0, 1) ? int'($urandom_range(0, 45)) : int'($urandom_range(1015, 1023)),
                   24'($urandom), 1'($urandom_range(0, 7) != 0));
      end
      frame(int'($urandom_range(0, W * H - 1)), int'($urandom_range(0, NM - 1)),
            int'($urandom_range(0, 70)), -1);
    end

    // Reset in the middle of a line, misaligned lines, then a clean frame.
    set_marker(0, 3, 12, 8, 24'hABCDEF, 1'b1);
    frame(-1, 0, 0, 3 * W + 20);
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < W; c++) drive(1'b1, 1'b0, -1, -1);
      drive(1'b0, 1'b0, -1, -1);
    end
    frame(-1, 0, 0, -1);

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
